bcd2bin_seq_ctrl: RTL and testbench
===================================

// Module: bcd2bin_seq_ctrl
// PURPOSE
//  Sequential BCD-to-binary converter built on reverse double-dabble (shift right, then subtract 3 from each digit >= 8).
//  One shared 4-bit add/sub cell (Adder_Subtractor, ctrl=1 -> a-b) serves all digits; an FSM sequences it one digit per cycle.
//  Sits between the BCD keypad/display front end and the binary datapath; start/busy/done handshake on both sides.
// PARAMETERS
//  NDIG   2  number of BCD digits in bcd_in (legal: 2,3,4)
//  BIN_W  7  binary result width; must equal ceil(log2(10^NDIG)) (7,10,14); elaboration error otherwise
// PORTS
//  clk      in   1        rising-edge clock
//  rst_n    in   1        asynchronous active-low reset
//  start    in   1        request; sampled only in IDLE
//  bcd_in   in   4*NDIG   packed BCD, digit 0 = bits[3:0]; sampled with start
//  busy     out  1        high while FSM != IDLE
//  done     out  1        one-cycle pulse: bin_out/err valid
//  err      out  1        valid with done; 1 = some digit > 9
//  bin_out  out  BIN_W    binary result; held until next done
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, busy=0, done=0, err=0, bin_out=0, shift reg=0, iter cnt=0. Deassertion is synchronised externally.
//  Work reg W = {digit[NDIG-1..0], bin[BIN_W-1:0]}, width 4*NDIG+BIN_W.
//  States: IDLE, SHIFT, ADJ(d) (d=0..NDIG-1), FIN.
//   IDLE: start=1 & all digits <= 9 -> W={bcd_in,0}, cnt=0, go SHIFT.
//         start=1 & any digit > 9 -> go FIN with err_nxt=1 (no conversion).
//   SHIFT: W>>=1 (zero fill), cnt++. If cnt becomes BIN_W -> FIN, else -> ADJ(0).
//   ADJ(d): add/sub cell: a=digit d, b=4'd3, ctrl=1. If digit d >= 8, digit d <= sum. Else unchanged. -> ADJ(d+1); from ADJ(NDIG-1) -> SHIFT.
//   FIN: done=1 for this cycle, bin_out<=W[BIN_W-1:0] (0 if err), err<=err_nxt. Then -> IDLE.
//  done, err and bin_out are registered; they update on the edge that enters the done cycle.
//  Carry-out of the cell is ignored: digit >= 8 minus 3 never borrows.
//  Latency: start sampled at edge N. done is high from edge N+L for 1 cycle, where L = BIN_W + (BIN_W-1)*NDIG (=19 for defaults).
//   Invalid input: done+err from edge N+1.
//  busy: 1 from edge N until the edge ending the done cycle; done and busy overlap in that cycle.
//  Next start is accepted on the first IDLE cycle after done, which is back-to-back capable.
//  start while busy: ignored, not queued. bcd_in changes while busy have no effect.
//  After completion, all BCD digits of W are 0 for valid input; this is an assertion check, not a port.
//  Reset mid-conversion: immediate abort to reset values; no done pulse.
// STRUCTURE
//  Package bcd2bin_pkg: FSM state enum/localparams, ADJ_VAL=4'd3, ADJ_THR=4'd8, BCD_MAX=4'd9, function bin_w_for(ndig).
//  Sub-module: one instance of Adder_Subtractor (shared, ctrl tied 1); digit mux/demux, FSM and counter live in this module.
//  Sub-module bcd2bin_digit_sel: NDIG:1 mux of the active digit plus write-back decode.
// TESTING
//  1 bcd_in=8'h99, start 1 cycle -> done at N+19, bin_out=7'h63, err=0; busy high N..N+19.
//  2 bcd_in=8'h00 -> bin_out=0. bcd_in=8'h47 -> bin_out=7'h2F. Exhaustive 00..99 -> bin_out==decimal value.
//  3 bcd_in=8'h3A -> done at N+1, err=1, bin_out=0. Next valid 8'h12 -> err=0, bin_out=12.
//  4 start pulsed again at N+5 with bcd_in=8'h11 during an 8'h99 conversion -> ignored; single done, bin_out=99.
//  5 rst_n low at N+7 mid-conversion -> outputs 0 asynchronously, no done. Fresh start 8'h50 -> bin_out=50 at +19.
//  6 NDIG=3, BIN_W=10, bcd_in=12'h999 -> done at N+37, bin_out=10'd999; start held high -> conversions back-to-back.

Source files
------------

// File: rtl/bcd2bin_seq_ctrl_pkg.sv
// Shared types, constants and helpers for the sequential BCD-to-binary converter.
// Provides the FSM state encoding, the reverse double-dabble adjust constants and the result-width rule.
package bcd2bin_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ADJ   = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    localparam logic [3:0] ADJ_VAL = 4'd3;
    localparam logic [3:0] ADJ_THR = 4'd8;
    localparam logic [3:0] BCD_MAX = 4'd9;

    // Smallest width able to hold 10^ndig - 1.
    function automatic int bin_w_for(input int ndig);
        longint p;
        int     w;
        p = 64'd1;
        for (int i = 0; i < ndig; i++) begin
            p = p * 64'd10;
        end
        w = 0;
        while ((64'd1 << w) < p) begin
            w = w + 1;
        end
        return w;
    endfunction

    function automatic logic digit_ok(input logic [3:0] d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd2bin_seq_ctrl_if.sv
// Request/response bundle between the BCD front end and the converter.
interface bcd2bin_seq_ctrl_if #(
    parameter int NDIG  = 2,
    parameter int BIN_W = 7
);
    logic                  start;
    logic [4*NDIG-1:0]     bcd_in;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [BIN_W-1:0]      bin_out;

    modport master (output start, output bcd_in,
                    input  busy,  input  done, input err, input bin_out);
    modport slave  (input  start, input  bcd_in,
                    output busy,  output done, output err, output bin_out);
endinterface

// File: rtl/bcd2bin_seq_ctrl_addsub.sv
// 4-bit adder/subtractor cell: ctrl=0 -> a+b, ctrl=1 -> a-b (two's complement).
module Adder_Subtractor (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ctrl,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] b_x_s;

    assign b_x_s       = b ^ {4{ctrl}};
    assign {cout, sum} = {1'b0, a} + {1'b0, b_x_s} + {4'b0000, ctrl};
endmodule

// File: rtl/bcd2bin_seq_ctrl_chk.sv
// Protocol and datapath invariants of the converter, kept apart from the design logic.
module bcd2bin_seq_ctrl_chk #(
    parameter int NDIG = 2
) (
    input logic              clk,
    input logic              rst_n,
    input logic              done,
    input logic              err,
    input logic              busy,
    input logic [4*NDIG-1:0] digits
);
    // A clean conversion must have drained every BCD digit into the binary field.
    a_digits_drained: assert property (@(posedge clk) disable iff (!rst_n)
        (done && !err) |-> (digits == '0));

    // done is always reported inside a busy window.
    a_done_in_busy: assert property (@(posedge clk) disable iff (!rst_n)
        done |-> busy);
endmodule

// File: rtl/bcd2bin_seq_ctrl_digit_sel.sv
// Selects the active BCD digit for the shared adjust cell and merges the adjusted digit back.
module bcd2bin_digit_sel #(
    parameter int NDIG  = 2,
    parameter int SEL_W = (NDIG > 1) ? $clog2(NDIG) : 1
) (
    input  logic [4*NDIG-1:0] digits,
    input  logic [SEL_W-1:0]  sel,
    input  logic [3:0]        wr_digit,
    input  logic              wr_en,
    output logic [3:0]        rd_digit,
    output logic [4*NDIG-1:0] digits_upd
);
    logic [3:0] dig_arr_s [NDIG];

    for (genvar i = 0; i < NDIG; i++) begin : g_dig
        assign dig_arr_s[i]         = digits[4*i +: 4];
        assign digits_upd[4*i +: 4] = (wr_en && (sel == SEL_W'(i))) ? wr_digit : digits[4*i +: 4];
    end

    assign rd_digit = dig_arr_s[sel];
endmodule

// File: rtl/bcd2bin_seq_ctrl.sv
// Sequential BCD-to-binary converter: reverse double-dabble, one shared 4-bit subtract cell,
// one digit adjusted per cycle between right shifts.
module bcd2bin_seq_ctrl
    import bcd2bin_pkg::*;
#(
    parameter int NDIG  = 2,
    parameter int BIN_W = 7
) (
    input logic               clk,
    input logic               rst_n,
    bcd2bin_seq_ctrl_if.slave bus
);
    localparam int W_W   = 4*NDIG + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int SEL_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NDIG - 1);
    localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);

    if ((NDIG < 2) || (NDIG > 4)) begin : g_bad_ndig
        $error("bcd2bin_seq_ctrl: NDIG must be 2..4");
    end
    if (BIN_W != bin_w_for(NDIG)) begin : g_bad_binw
        $error("bcd2bin_seq_ctrl: BIN_W must equal ceil(log2(10^NDIG))");
    end

    state_t             state_r;
    logic [W_W-1:0]     work_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [SEL_W-1:0]   sel_r;
    logic               err_nxt_r;
    logic               busy_r;
    logic               done_r;
    logic               err_r;
    logic [BIN_W-1:0]   bin_r;

    logic [4*NDIG-1:0]  digits_s;
    logic [4*NDIG-1:0]  digits_upd_s;
    logic [W_W-1:0]     shifted_s;
    logic [3:0]         cur_digit_s;
    logic [3:0]         diff_s;
    logic               adj_we_s;
    logic               in_ok_s;
    logic               addsub_cout_unused;

    assign digits_s  = work_r[W_W-1:BIN_W];
    assign shifted_s = {1'b0, work_r[W_W-1:1]};
    assign adj_we_s  = (cur_digit_s >= ADJ_THR);

    bcd2bin_digit_sel #(.NDIG(NDIG), .SEL_W(SEL_W)) u_digit_sel (
        .digits     (digits_s),
        .sel        (sel_r),
        .wr_digit   (diff_s),
        .wr_en      (adj_we_s),
        .rd_digit   (cur_digit_s),
        .digits_upd (digits_upd_s)
    );

    // A digit >= 8 minus 3 never underflows, so the carry out carries no information.
    Adder_Subtractor u_addsub (
        .a    (cur_digit_s),
        .b    (ADJ_VAL),
        .ctrl (1'b1),
        .sum  (diff_s),
        .cout (addsub_cout_unused)
    );

    // Input validity: every incoming digit must be a legal BCD value.
    always_comb begin
        in_ok_s = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            in_ok_s = in_ok_s & digit_ok(bus.bcd_in[4*i +: 4]);
        end
    end

    // Conversion sequencer with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            work_r    <= '0;
            cnt_r     <= '0;
            sel_r     <= '0;
            err_nxt_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            bin_r     <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start && in_ok_s) begin
                        work_r    <= {bus.bcd_in, {BIN_W{1'b0}}};
                        cnt_r     <= '0;
                        sel_r     <= '0;
                        err_nxt_r <= 1'b0;
                        busy_r    <= 1'b1;
                        state_r   <= ST_SHIFT;
                    end else if (bus.start) begin
                        err_nxt_r <= 1'b1;
                        busy_r    <= 1'b1;
                        state_r   <= ST_FIN;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    work_r <= shifted_s;
                    cnt_r  <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        done_r  <= 1'b1;
                        err_r   <= 1'b0;
                        bin_r   <= shifted_s[BIN_W-1:0];
                        state_r <= ST_FIN;
                    end else begin
                        sel_r   <= '0;
                        state_r <= ST_ADJ;
                    end
                end
                ST_ADJ: begin
                    work_r <= {digits_upd_s, work_r[BIN_W-1:0]};
                    if (sel_r == SEL_LAST) begin
                        sel_r   <= '0;
                        state_r <= ST_SHIFT;
                    end else begin
                        sel_r   <= sel_r + SEL_ONE;
                        state_r <= ST_ADJ;
                    end
                end
                ST_FIN: begin
                    // Rejected input arrives here with done still low; raise it for one cycle first.
                    if (done_r) begin
                        done_r  <= 1'b0;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        done_r  <= 1'b1;
                        err_r   <= err_nxt_r;
                        bin_r   <= '0;
                        state_r <= ST_FIN;
                    end
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.err     = err_r;
    assign bus.bin_out = bin_r;

    bcd2bin_seq_ctrl_chk #(.NDIG(NDIG)) u_chk (
        .clk    (clk),
        .rst_n  (rst_n),
        .done   (done_r),
        .err    (err_r),
        .busy   (busy_r),
        .digits (digits_s)
    );
endmodule

// File: tb/tb_bcd2bin_seq_ctrl.sv
// Scoreboard bench for bcd2bin_seq_ctrl: 2-digit and 3-digit instances, directed vectors.
module tb_bcd2bin_seq_ctrl;

    typedef struct {
        int     bin;
        bit     err;
        longint cyc;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    longint cyc = 0;
    int     n_tests = 0;
    int     n_fail = 0;
    exp_t   q2[$];
    exp_t   q3[$];

    bcd2bin_seq_ctrl_if #(.NDIG(2), .BIN_W(7))  if2 ();
    bcd2bin_seq_ctrl_if #(.NDIG(3), .BIN_W(10)) if3 ();

    bcd2bin_seq_ctrl #(.NDIG(2), .BIN_W(7))  dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    bcd2bin_seq_ctrl #(.NDIG(3), .BIN_W(10)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push2(input int b, input bit e, input longint c);
        exp_t x;
        x.bin = b; x.err = e; x.cyc = c;
        q2.push_back(x);
    endtask

    task automatic push3(input int b, input bit e, input longint c);
        exp_t x;
        x.bin = b; x.err = e; x.cyc = c;
        q3.push_back(x);
    endtask

    // Monitor for the 2-digit instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && if2.done) begin
            if (q2.size() == 0) begin
                chk("unexpected_done2", 1, 0);
            end else begin
                e = q2.pop_front();
                chk("bin2", if2.bin_out, e.bin);
                chk("err2", if2.err, e.err);
                chk("done_cycle2", cyc, e.cyc);
                chk("busy_with_done2", if2.busy, 1);
            end
        end
    end

    // Monitor for the 3-digit instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && if3.done) begin
            if (q3.size() == 0) begin
                chk("unexpected_done3", 1, 0);
            end else begin
                e = q3.pop_front();
                chk("bin3", if3.bin_out, e.bin);
                chk("err3", if3.err, e.err);
                chk("done_cycle3", cyc, e.cyc);
                chk("busy_with_done3", if3.busy, 1);
            end
        end
    end

    task automatic wait_idle2();
        bit ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (q2.size() == 0 && !if2.busy) ok = 1'b1;
        end
        if (!ok) chk("timeout2", 0, 1);
    endtask

    task automatic wait_idle3();
        bit ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            if (q3.size() == 0 && !if3.busy) ok = 1'b1;
        end
        if (!ok) chk("timeout3", 0, 1);
    endtask

    // Issue one 2-digit request from a negedge; lat is edges from sampling to done.
    task automatic run2(input logic [7:0] bcd, input int eb, input bit ee, input int lat);
        push2(eb, ee, cyc + 1 + lat);
        if2.bcd_in = bcd;
        if2.start  = 1'b1;
        @(negedge clk);
        if2.start  = 1'b0;
        wait_idle2();
    endtask

    task automatic run3(input logic [11:0] bcd, input int eb, input bit ee, input int lat);
        push3(eb, ee, cyc + 1 + lat);
        if3.bcd_in = bcd;
        if3.start  = 1'b1;
        @(negedge clk);
        if3.start  = 1'b0;
        wait_idle3();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         busy_ok;
        logic [3:0] tv;
        logic [3:0] ov;

        if2.start = 1'b0; if2.bcd_in = 8'h00;
        if3.start = 1'b0; if3.bcd_in = 12'h000;
        repeat (2) @(negedge clk);
        chk("rst_busy", if2.busy, 0);
        chk("rst_done", if2.done, 0);
        chk("rst_err", if2.err, 0);
        chk("rst_bin", if2.bin_out, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 99 with busy window N..N+19.
        push2(99, 1'b0, cyc + 1 + 19);
        if2.bcd_in = 8'h99;
        if2.start  = 1'b1;
        @(negedge clk);
        if2.start  = 1'b0;
        busy_ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (!if2.busy) busy_ok = 1'b0;
            @(negedge clk);
        end
        chk("busy_window", busy_ok, 1);
        chk("busy_released", if2.busy, 0);
        wait_idle2();

        run2(8'h00, 0, 1'b0, 19);
        run2(8'h47, 47, 1'b0, 19);
        run2(8'h3A, 0, 1'b1, 1);
        run2(8'h12, 12, 1'b0, 19);
        run2(8'hA5, 0, 1'b1, 1);
        run2(8'h80, 80, 1'b0, 19);

        for (int t = 0; t < 10; t++) begin
            for (int o = 0; o < 10; o++) begin
                tv = 4'(t);
                ov = 4'(o);
                run2({tv, ov}, t*10 + o, 1'b0, 19);
            end
        end

        // Start re-pulsed mid-conversion must be ignored.
        push2(99, 1'b0, cyc + 1 + 19);
        if2.bcd_in = 8'h99;
        if2.start  = 1'b1;
        @(negedge clk);
        if2.start  = 1'b0;
        repeat (4) @(negedge clk);
        if2.bcd_in = 8'h11;
        if2.start  = 1'b1;
        @(negedge clk);
        if2.start  = 1'b0;
        wait_idle2();
        chk("held_bin", if2.bin_out, 99);

        // Reset mid-conversion: no done, outputs clear at once.
        if2.bcd_in = 8'h99;
        if2.start  = 1'b1;
        @(negedge clk);
        if2.start  = 1'b0;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", if2.busy, 0);
        chk("abort_bin", if2.bin_out, 0);
        chk("abort_done", if2.done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run2(8'h50, 50, 1'b0, 19);

        // Three digits, start held high: 999 then back-to-back 123.
        run3(12'h000, 0, 1'b0, 37);
        run3(12'h9B1, 0, 1'b1, 1);
        push3(999, 1'b0, cyc + 1 + 37);
        push3(123, 1'b0, cyc + 1 + 37 + 39);
        if3.bcd_in = 12'h999;
        if3.start  = 1'b1;
        repeat (4) @(negedge clk);
        if3.bcd_in = 12'h123;
        repeat (42) @(negedge clk);
        if3.start  = 1'b0;
        wait_idle3();

        repeat (5) @(negedge clk);
        chk("q2_drained", q2.size(), 0);
        chk("q3_drained", q3.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
